// File: rtl/aes_key_schedule.sv
// ---------------------------------------------------------------------------
// sbox
//   AES forward S-box, purely combinational.
//   Computes the multiplicative inverse in GF(2^8) (x^254, with 0 -> 0)
//   and applies the AES affine transform.
//   Ports:
//     din   [7:0]  input byte
//     dout  [7:0]  substituted byte
// ---------------------------------------------------------------------------
module sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        logic [7:0] bb;
        acc = 8'h00;
        aa  = a;
        bb  = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) begin
                acc = acc ^ aa;
            end else begin
                acc = acc;
            end
            if (aa[7]) begin
                aa = {aa[6:0], 1'b0} ^ 8'h1b;
            end else begin
                aa = {aa[6:0], 1'b0};
            end
            bb = {1'b0, bb[7:1]};
        end
        return acc;
    endfunction

    // x^254 = x^(2+4+8+16+32+64+128): accumulate successive squares.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] res;
        logic [7:0] sq;
        res = 8'h01;
        sq  = x;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    logic [7:0] inv_s;

    // Inverse followed by the affine transform (rotations of the inverse plus 0x63).
    always_comb begin
        inv_s = gf_inv(din);
        dout  = inv_s
              ^ {inv_s[6:0], inv_s[7]}
              ^ {inv_s[5:0], inv_s[7:6]}
              ^ {inv_s[4:0], inv_s[7:5]}
              ^ {inv_s[3:0], inv_s[7:4]}
              ^ 8'h63;
    end

endmodule

// ---------------------------------------------------------------------------
// aes_key_schedule
//   On-the-fly AES-128/192/256 key expansion. One 32-bit schedule word is
//   generated per cycle; every fourth word completes a 128-bit round key that
//   is offered on a valid/ready interface.
//   Ports:
//     clk       clock, rising edge
//     reset     synchronous active-high reset
//     start     begin expansion (accepted only while idle)
//     mode      0=AES-128, 1=AES-192, 2=AES-256, 3=illegal
//     key_in    cipher key, word 0 in the top 32 bits
//     busy      expansion in progress
//     rk_valid  round key available on rk_data/rk_round
//     rk_ready  consumer accepts the round key
//     rk_data   round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//     rk_round  round index r
//     done      one-cycle pulse after the final round key is accepted
//     mode_err  one-cycle pulse after a start with an unsupported mode
// ---------------------------------------------------------------------------
module aes_key_schedule #(
    parameter int KEY_BITS = 256,
    parameter int RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk_data,
    output logic [RK_IDX_W-1:0] rk_round,
    output logic                done,
    output logic                mode_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Round constants; index 0 is used by the first word derived from the key.
    function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    state_t                state_r;
    state_t                state_nxt_s;

    logic [KEY_BITS-1:0]   key_r;
    // win_r[k] holds w[i-1-k]; only the newest Nk entries are ever read.
    logic [31:0]           win_r [0:7];
    logic [5:0]            word_idx_r;   // i
    logic [2:0]            word_mod_r;   // i mod Nk
    logic [3:0]            rcon_idx_r;
    logic [2:0]            nk_m1_r;      // Nk-1
    logic [5:0]            last_idx_r;   // 4(Nr+1)-1

    logic                  busy_r;
    logic                  rk_valid_r;
    logic [127:0]          rk_data_r;
    logic [RK_IDX_W-1:0]   rk_round_r;
    logic                  done_r;
    logic                  mode_err_r;

    logic [31:0]           key_words_s [0:7];
    logic [31:0]           mode_bits_s;
    logic                  mode_illegal_s;
    logic                  accept_s;
    logic                  stall_s;
    logic                  advance_s;
    logic                  rk_take_s;
    logic                  rk_load_s;
    logic                  last_word_s;
    logic                  key_phase_s;
    logic [31:0]           w_prev_s;
    logic [31:0]           w_back_s;
    logic [31:0]           sub_in_s;
    logic [31:0]           sub_out_s;
    logic [31:0]           new_word_s;

    // Split the latched key into 32-bit words, word 0 at the MSB end.
    genvar gj;
    generate
        for (gj = 0; gj < 8; gj++) begin : g_key_words
            if (32 * (gj + 1) <= KEY_BITS) begin : g_present
                assign key_words_s[gj] = key_r[KEY_BITS-1-32*gj -: 32];
            end else begin : g_absent
                assign key_words_s[gj] = 32'h0000_0000;
            end
        end
    endgenerate

    // Four byte substitutions form SubWord.
    genvar gb;
    generate
        for (gb = 0; gb < 4; gb++) begin : g_sbox
            sbox u_sbox (
                .din  (sub_in_s[8*gb +: 8]),
                .dout (sub_out_s[8*gb +: 8])
            );
        end
    endgenerate

    // Mode legality and handshake qualifiers.
    always_comb begin
        case (mode)
            2'd0:    mode_bits_s = 32'd128;
            2'd1:    mode_bits_s = 32'd192;
            2'd2:    mode_bits_s = 32'd256;
            default: mode_bits_s = 32'd0;
        endcase
        mode_illegal_s = (mode_bits_s == 32'd0) || (mode_bits_s > 32'(KEY_BITS));
        accept_s       = (state_r == IDLE) && start && !mode_illegal_s;
        stall_s        = rk_valid_r && !rk_ready;
        advance_s      = (state_r == EXPAND) && !stall_s;
        rk_take_s      = rk_valid_r && rk_ready;
        last_word_s    = (word_idx_r == last_idx_r);
        rk_load_s      = advance_s && (word_idx_r[1:0] == 2'd3);
        key_phase_s    = (word_idx_r <= {3'd0, nk_m1_r});
    end

    // SubWord operand: rotated previous word at the start of each Nk group.
    always_comb begin
        w_prev_s = win_r[0];
        w_back_s = win_r[nk_m1_r];
        if (word_mod_r == 3'd0) begin
            sub_in_s = {w_prev_s[23:0], w_prev_s[31:24]};
        end else begin
            sub_in_s = w_prev_s;
        end
    end

    // Next schedule word.
    always_comb begin
        new_word_s = 32'h0000_0000;
        if (key_phase_s) begin
            new_word_s = key_words_s[word_idx_r[2:0]];
        end else if (word_mod_r == 3'd0) begin
            new_word_s = w_back_s ^ sub_out_s ^ {rcon_byte(rcon_idx_r), 24'h00_0000};
        end else if ((nk_m1_r == 3'd7) && (word_mod_r == 3'd4)) begin
            new_word_s = w_back_s ^ sub_out_s;
        end else begin
            new_word_s = w_back_s ^ w_prev_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = EXPAND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXPAND: begin
                if (advance_s && last_word_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = EXPAND;
                end
            end
            DRAIN: begin
                if (rk_take_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Key latch, word window and schedule counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_r      <= '0;
            word_idx_r <= 6'd0;
            word_mod_r <= 3'd0;
            rcon_idx_r <= 4'd0;
            nk_m1_r    <= 3'd3;
            last_idx_r <= 6'd43;
            for (int k = 0; k < 8; k++) begin
                win_r[k] <= 32'h0000_0000;
            end
        end else if (accept_s) begin
            key_r      <= key_in;
            word_idx_r <= 6'd0;
            word_mod_r <= 3'd0;
            rcon_idx_r <= 4'd0;
            case (mode)
                2'd1: begin
                    nk_m1_r    <= 3'd5;
                    last_idx_r <= 6'd51;
                end
                2'd2: begin
                    nk_m1_r    <= 3'd7;
                    last_idx_r <= 6'd59;
                end
                default: begin
                    nk_m1_r    <= 3'd3;
                    last_idx_r <= 6'd43;
                end
            endcase
        end else if (advance_s) begin
            for (int k = 7; k > 0; k--) begin
                win_r[k] <= win_r[k-1];
            end
            win_r[0]   <= new_word_s;
            word_idx_r <= word_idx_r + 6'd1;
            if (word_mod_r == nk_m1_r) begin
                word_mod_r <= 3'd0;
            end else begin
                word_mod_r <= word_mod_r + 3'd1;
            end
            // Rcon advances once per Nk group, after its first use.
            if (!key_phase_s && (word_mod_r == 3'd0)) begin
                rcon_idx_r <= rcon_idx_r + 4'd1;
            end
        end
    end

    // Round-key output register and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r     <= 1'b0;
            rk_valid_r <= 1'b0;
            rk_data_r  <= 128'h0;
            rk_round_r <= '0;
            done_r     <= 1'b0;
            mode_err_r <= 1'b0;
        end else begin
            if (accept_s) begin
                busy_r <= 1'b1;
            end else if ((state_r == DRAIN) && rk_take_s) begin
                busy_r <= 1'b0;
            end
            // A fresh load on the same edge as a transfer keeps valid high.
            if (rk_load_s) begin
                rk_valid_r <= 1'b1;
                rk_data_r  <= {win_r[2], win_r[1], win_r[0], new_word_s};
                rk_round_r <= RK_IDX_W'(word_idx_r[5:2]);
            end else if (rk_take_s) begin
                rk_valid_r <= 1'b0;
            end
            done_r     <= (state_r == DRAIN) && rk_take_s;
            mode_err_r <= (state_r == IDLE) && start && mode_illegal_s;
        end
    end

    assign busy     = busy_r;
    assign rk_valid = rk_valid_r;
    assign rk_data  = rk_data_r;
    assign rk_round = rk_round_r;
    assign done     = done_r;
    assign mode_err = mode_err_r;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: a reference key expansion fills a
// scoreboard queue when a key is issued; a monitor pops and compares on every
// round-key transfer.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   mode;
    logic [255:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         done;
    logic         mode_err;

    always #5 clk = ~clk;

    aes_key_schedule #(.KEY_BITS(256), .RK_IDX_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_round (rk_round),
        .done     (done),
        .mode_err (mode_err)
    );

    typedef struct packed {
        logic         last;
        logic [3:0]   round;
        logic [127:0] data;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           failures = 0;
    int           xfers = 0;
    bit           expect_done = 1'b0;
    bit           done_seen = 1'b0;
    logic [7:0]   sbox_tab [0:255];
    logic [7:0]   rcon_tab [0:15];
    logic [127:0] exp_rk [0:14];
    int           exp_nrk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return (x[7]) ? ((x << 1) ^ 8'h1b) : (x << 1);
    endfunction

    // S-box via the generator-3 walk of the multiplicative group.
    task automatic build_tables();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ ((p & 8'h80) != 8'h00 ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if ((q & 8'h80) != 8'h00) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_tab[0] = 8'h63;
        rcon_tab[0] = 8'h00;
        rcon_tab[1] = 8'h01;
        for (int k = 2; k < 16; k++) rcon_tab[k] = xtime(rcon_tab[k-1]);
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
    endfunction

    // FIPS-197 key expansion over a full word array.
    task automatic model(input int m, input logic [255:0] key);
        logic [31:0] w [0:59];
        logic [31:0] t;
        int nk;
        int nr;
        nk = 4 + 2 * m;
        nr = nk + 6;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32 * i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0)
                    t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i / nk], 24'h000000};
                else if (nk == 8 && i % nk == 4)
                    t = subw(t);
                w[i] = w[i-nk] ^ t;
            end
        end
        exp_nrk = nr + 1;
        for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    // Build expectations, queue them, and pulse start (accepted at the next edge).
    task automatic issue(input int m, input logic [255:0] key,
                         input int k1r, input logic [127:0] k1v,
                         input int k2r, input logic [127:0] k2v);
        exp_t e;
        model(m, key);
        if (k1r >= 0) exp_rk[k1r] = k1v;
        if (k2r >= 0) exp_rk[k2r] = k2v;
        for (int r = 0; r < exp_nrk; r++) begin
            e.last  = (r == exp_nrk - 1);
            e.round = 4'(r);
            e.data  = exp_rk[r];
            sb.push_back(e);
        end
        xfers     = 0;
        done_seen = 1'b0;
        @(posedge clk); #1;
        start  = 1'b1;
        mode   = 2'(m);
        key_in = key;
        @(posedge clk); #1;
        start  = 1'b0;
        key_in = rand256();
    endtask

    task automatic wait_done(input string name, input int nkeys, input bit rand_ready);
        for (int n = 0; n < 3000; n++) begin
            if (done_seen) break;
            @(posedge clk); #1;
            rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        rk_ready = 1'b1;
        chk({name, " done_seen"}, 128'(done_seen), 128'd1);
        chk({name, " transfers"}, 128'(xfers), 128'(nkeys));
        chk({name, " queue_empty"}, 128'(sb.size()), 128'd0);
        @(negedge clk);
        chk({name, " busy_after"}, 128'(busy), 128'd0);
    endtask

    // Monitor: compare every transfer with the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                expect_done = 1'b0;
            end else begin
                if (expect_done) begin
                    chk("done_pulse", 128'(done), 128'd1);
                    expect_done = 1'b0;
                    done_seen   = 1'b1;
                end else begin
                    chk("done_quiet", 128'(done), 128'd0);
                end
                if (rk_valid && rk_ready) begin
                    xfers++;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_key: got round %0d data %h, expected none", rk_round, rk_data);
                    end else begin
                        e = sb.pop_front();
                        chk("rk_round", 128'(rk_round), 128'(e.round));
                        chk("rk_data", rk_data, e.data);
                        if (e.last) expect_done = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        bit found;
        int m;
        build_tables();
        reset    = 1'b1;
        start    = 1'b0;
        mode     = 2'd0;
        key_in   = '0;
        rk_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset rk_valid", 128'(rk_valid), 128'd0);
        chk("reset rk_data", rk_data, 128'd0);
        chk("reset rk_round", 128'(rk_round), 128'd0);
        chk("reset done", 128'(done), 128'd0);
        chk("reset mode_err", 128'(mode_err), 128'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // AES-128 all-zero key with latency check; low bits are don't-care junk.
        issue(0, {128'h0, rand256() >> 128}, 1, 128'h62636363626363636263636362636363,
              10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("latency rk_valid", 128'(rk_valid), 128'(k == 4));
        end
        wait_done("aes128_zero", 11, 1'b0);

        issue(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 10,
              128'hd014f9a8c9ee2589e13f0cc8b6630ca6, -1, 128'h0);
        wait_done("aes128_fips", 11, 1'b0);

        issue(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hdeadbeefcafef00d},
              12, 128'he98ba06f448c773c8ecc720401002202, -1, 128'h0);
        wait_done("aes192_fips", 13, 1'b0);

        issue(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
              14, 128'hfe4890d1e6188d0b046df344706c631e, -1, 128'h0);
        wait_done("aes256_fips", 15, 1'b1);

        // Illegal mode.
        @(posedge clk); #1;
        start = 1'b1;
        mode  = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 2'd0;
        @(negedge clk);
        chk("mode_err pulse", 128'(mode_err), 128'd1);
        chk("mode_err busy", 128'(busy), 128'd0);
        @(negedge clk);
        chk("mode_err clears", 128'(mode_err), 128'd0);
        chk("mode_err idle", 128'(busy), 128'd0);

        // Backpressure at round 3, plus a start pulse while busy.
        issue(0, rand256(), -1, 128'h0, -1, 128'h0);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (rk_valid && rk_round == 4'd3) begin
                found = 1'b1;
                break;
            end
        end
        chk("stall reached round3", 128'(found), 128'd1);
        rk_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall rk_valid", 128'(rk_valid), 128'd1);
            chk("stall rk_round", 128'(rk_round), 128'd3);
            chk("stall rk_data", rk_data, exp_rk[3]);
            chk("stall busy", 128'(busy), 128'd1);
            @(posedge clk); #1;
            start  = (k == 3);
            mode   = 2'd2;
            key_in = rand256();
        end
        start    = 1'b0;
        rk_ready = 1'b1;
        wait_done("backpressure", 11, 1'b0);

        // Reset in the middle of an AES-192 expansion, then a fresh run.
        issue(1, rand256(), -1, 128'h0, -1, 128'h0);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (rk_valid && rk_round == 4'd5) begin
                found = 1'b1;
                break;
            end
        end
        chk("reset reached round5", 128'(found), 128'd1);
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midreset rk_valid", 128'(rk_valid), 128'd0);
        chk("midreset busy", 128'(busy), 128'd0);
        chk("midreset rk_round", 128'(rk_round), 128'd0);
        issue(1, rand256(), -1, 128'h0, -1, 128'h0);
        wait_done("after_reset", 13, 1'b0);

        // Random keys and modes under random backpressure.
        for (int t = 0; t < 6; t++) begin
            m = $urandom_range(0, 2);
            issue(m, rand256(), -1, 128'h0, -1, 128'h0);
            wait_done("random", 11 + 2 * m, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
